// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input front end: joystick bit map, PS/2 scancodes,
// held-key record and coin FSM states.
package arcade_input_pkg;

    localparam int JOY_R      = 0;
    localparam int JOY_L      = 1;
    localparam int JOY_D      = 2;
    localparam int JOY_U      = 3;
    localparam int JOY_FIRE   = 4;
    localparam int JOY_START1 = 5;
    localparam int JOY_START2 = 6;
    localparam int JOY_COIN   = 7;

    // 9-bit codes: {extended (E0) flag, scancode}
    localparam logic [8:0] SC_P1_UP     = 9'h175;
    localparam logic [8:0] SC_P1_DOWN   = 9'h172;
    localparam logic [8:0] SC_P1_LEFT   = 9'h16B;
    localparam logic [8:0] SC_P1_RIGHT  = 9'h174;
    localparam logic [8:0] SC_P1_FIRE_A = 9'h029;
    localparam logic [8:0] SC_P1_FIRE_B = 9'h014;
    localparam logic [8:0] SC_P1_FIRE_C = 9'h114;
    localparam logic [8:0] SC_P2_RIGHT  = 9'h023;
    localparam logic [8:0] SC_P2_LEFT   = 9'h01C;
    localparam logic [8:0] SC_P2_FIRE   = 9'h015;
    localparam logic [8:0] SC_START1_A  = 9'h005;
    localparam logic [8:0] SC_START1_B  = 9'h016;
    localparam logic [8:0] SC_START2_A  = 9'h006;
    localparam logic [8:0] SC_START2_B  = 9'h01E;
    localparam logic [8:0] SC_COIN_A    = 9'h02E;
    localparam logic [8:0] SC_COIN_B    = 9'h036;

    typedef struct packed {
        logic p1_up;
        logic p1_down;
        logic p1_left;
        logic p1_right;
        logic p1_fire;
        logic p2_right;
        logic p2_left;
        logic p2_fire;
        logic start1;
        logic start2;
        logic coin;
    } key_held_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

endpackage

// File: rtl/coin_pulse_gen.sv
// Rising edge of i_req starts a COIN_PULSE_CYC-cycle pulse on o_coin (asserted on the edge
// after the request), followed by a COIN_GAP_CYC lockout; requests during pulse/lockout are dropped.
module coin_pulse_gen
    import arcade_input_pkg::*;
#(
    parameter logic [23:0] COIN_PULSE_CYC = 24'd4_800_000,
    parameter logic [23:0] COIN_GAP_CYC   = 24'd4_800_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req,
    output logic o_coin
);

    coin_state_t r_state;
    logic [23:0] r_cnt;
    logic        r_req_d;
    logic        r_coin;
    logic        w_req_rise;

    // r_req_d tracks the request in every state, so a level held through the lockout never retriggers
    assign w_req_rise = i_req & ~r_req_d;
    assign o_coin     = r_coin;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_req_d <= 1'b0;
            r_coin  <= 1'b0;
        end else begin
            r_req_d <= i_req;
            case (r_state)
                IDLE: begin
                    if (w_req_rise) begin
                        r_state <= PULSE;
                        r_cnt   <= '0;
                        r_coin  <= 1'b1;
                    end
                end
                PULSE: begin
                    if (r_cnt == COIN_PULSE_CYC - 24'd1) begin
                        r_state <= GAP;
                        r_cnt   <= '0;
                        r_coin  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                GAP: begin
                    if (r_cnt == COIN_GAP_CYC - 24'd1) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_coin  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Merges PS/2 key events with both joysticks into registered player controls plus a timed coin.
// Every control output follows its sampled input by one cycle.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter logic [23:0] COIN_PULSE_CYC = 24'd4_800_000,
    parameter logic [23:0] COIN_GAP_CYC   = 24'd4_800_000,
    parameter logic        AUTO_COIN      = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        cabinet,
    input  logic        kbd_clear,
    output logic        right1,
    output logic        left1,
    output logic        fire1,
    output logic        right2,
    output logic        left2,
    output logic        fire2,
    output logic        start1,
    output logic        start2,
    output logic        coin1
);

    key_held_t r_held;
    key_held_t w_held_nxt;
    logic      r_old_tog;
    logic      r_primed;
    logic      w_event;
    logic      w_pressed;
    logic [8:0] w_code;
    logic      w_p1_right, w_p1_left, w_p1_fire;
    logic      w_p2_right, w_p2_left, w_p2_fire;
    logic      w_start1, w_start2, w_coin_req;
    logic      w_unused;

    // the toggle level present at reset release is not an event
    assign w_event   = r_primed & (ps2_key[10] ^ r_old_tog);
    assign w_pressed = ps2_key[9];
    assign w_code    = ps2_key[8:0];

    always_comb begin
        w_held_nxt = r_held;
        if (kbd_clear) begin
            w_held_nxt = '0;
        end else if (w_event) begin
            case (w_code)
                SC_P1_UP:     w_held_nxt.p1_up    = w_pressed;
                SC_P1_DOWN:   w_held_nxt.p1_down  = w_pressed;
                SC_P1_LEFT:   w_held_nxt.p1_left  = w_pressed;
                SC_P1_RIGHT:  w_held_nxt.p1_right = w_pressed;
                SC_P1_FIRE_A,
                SC_P1_FIRE_B,
                SC_P1_FIRE_C: w_held_nxt.p1_fire  = w_pressed;
                SC_P2_RIGHT:  w_held_nxt.p2_right = w_pressed;
                SC_P2_LEFT:   w_held_nxt.p2_left  = w_pressed;
                SC_P2_FIRE:   w_held_nxt.p2_fire  = w_pressed;
                SC_START1_A,
                SC_START1_B:  w_held_nxt.start1   = w_pressed;
                SC_START2_A,
                SC_START2_B:  w_held_nxt.start2   = w_pressed;
                SC_COIN_A,
                SC_COIN_B:    w_held_nxt.coin     = w_pressed;
                default:      w_held_nxt = r_held;
            endcase
        end
    end

    // merge uses the next-state held bits so a key event reaches the outputs in one cycle
    assign w_p1_right = w_held_nxt.p1_right | joystick_0[JOY_R];
    assign w_p1_left  = w_held_nxt.p1_left  | joystick_0[JOY_L];
    assign w_p1_fire  = w_held_nxt.p1_fire  | joystick_0[JOY_FIRE];
    assign w_p2_right = w_held_nxt.p2_right | joystick_1[JOY_R];
    assign w_p2_left  = w_held_nxt.p2_left  | joystick_1[JOY_L];
    assign w_p2_fire  = w_held_nxt.p2_fire  | joystick_1[JOY_FIRE];
    assign w_start1   = w_held_nxt.start1 | joystick_0[JOY_START1] | joystick_1[JOY_START1];
    assign w_start2   = w_held_nxt.start2 | joystick_0[JOY_START2] | joystick_1[JOY_START2];
    assign w_coin_req = w_held_nxt.coin | joystick_0[JOY_COIN] | joystick_1[JOY_COIN]
                      | (AUTO_COIN & (w_start1 | w_start2));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_old_tog <= 1'b0;
            r_primed  <= 1'b0;
            r_held    <= '0;
            right1    <= 1'b0;
            left1     <= 1'b0;
            fire1     <= 1'b0;
            right2    <= 1'b0;
            left2     <= 1'b0;
            fire2     <= 1'b0;
            start1    <= 1'b0;
            start2    <= 1'b0;
        end else begin
            r_old_tog <= ps2_key[10];
            r_primed  <= 1'b1;
            r_held    <= w_held_nxt;
            right1    <= w_p1_right;
            left1     <= w_p1_left;
            fire1     <= w_p1_fire;
            // upright cabinets share one panel, so P2 follows P1 as well
            right2    <= cabinet ? w_p2_right : (w_p1_right | w_p2_right);
            left2     <= cabinet ? w_p2_left  : (w_p1_left  | w_p2_left);
            fire2     <= cabinet ? w_p2_fire  : (w_p1_fire  | w_p2_fire);
            start1    <= w_start1;
            start2    <= w_start2;
        end
    end

    coin_pulse_gen #(
        .COIN_PULSE_CYC (COIN_PULSE_CYC),
        .COIN_GAP_CYC   (COIN_GAP_CYC)
    ) u_coin1 (
        .i_clk   (clk_sys),
        .i_rst_n (reset_n),
        .i_req   (w_coin_req),
        .o_coin  (coin1)
    );

    // up/down are tracked for future cores; this build has no vertical controls
    assign w_unused = ^{r_held.p1_up, r_held.p1_down,
                        joystick_0[15:8], joystick_0[JOY_U], joystick_0[JOY_D],
                        joystick_1[15:8], joystick_1[JOY_U], joystick_1[JOY_D]};

endmodule
